// File: rtl/spi_master_pkg.sv
// Shared SPI definitions: FSM state encoding, default word width and mode constants.
// The SPI slave in the DDS control path uses the same mode constants.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_HOLD     = 3'd4
  } state_t;

  localparam int unsigned SPI_B_DEFAULT   = 8;
  localparam int unsigned SPI_DIV_DEFAULT = 2;

  // Mode 0 style framing: sclk idles low, words go out LSB first.
  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_LSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_master_sclk_gen.sv
// DIV-cycle phase divider: o_tick_c marks the last clk cycle of each sclk phase.
// Held cleared while disabled, so every frame starts on a phase boundary.
module spi_master_sclk_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick_c = i_en && (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-word SPI master: start + parallel word in, LSB-first serial frame out,
// received word returned with a one-cycle done pulse. All outputs registered.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned B   = SPI_B_DEFAULT,
  parameter int unsigned DIV = SPI_DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [B-1:0] wordin,
  output logic [B-1:0] wordout,
  output logic         busy,
  output logic         done,
  output logic         sclk,
  output logic         ss,
  output logic         mosi,
  input  logic         miso
);

  localparam int unsigned CNTW = $clog2(B + 1);

  state_t          r_state, w_state_nxt;
  logic [B-1:0]    r_tx, w_tx_nxt;
  logic [B-1:0]    r_rx, w_rx_nxt;
  logic [B-1:0]    r_wordout, w_wordout_nxt;
  logic [CNTW-1:0] r_bitcnt, w_bitcnt_nxt;
  logic            r_mosi, w_mosi_nxt;
  logic            r_ss, w_ss_nxt;
  logic            r_sclk, w_sclk_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            w_div_en;
  logic            w_tick;

  assign w_div_en = (r_state != ST_IDLE);

  spi_master_sclk_gen #(
    .DIV(DIV)
  ) u_sclk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_div_en),
    .o_tick_c(w_tick)
  );

  // Next-state and next-output logic; pin outputs follow the next state so they
  // change on the same edge as the state register.
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_wordout_nxt = r_wordout;
    w_bitcnt_nxt  = r_bitcnt;
    w_mosi_nxt    = r_mosi;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_SETUP;
          w_tx_nxt     = wordin;
          w_mosi_nxt   = wordin[0];
          w_bitcnt_nxt = '0;
        end
      end
      ST_SETUP: begin
        if (w_tick) w_state_nxt = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        // Falling sclk: capture miso, advance mosi unless this was the last bit.
        if (w_tick) begin
          w_state_nxt  = ST_SHIFT_LO;
          w_rx_nxt     = {miso, r_rx[B-1:1]};
          w_bitcnt_nxt = r_bitcnt + CNTW'(1);
          if (r_bitcnt < CNTW'(B - 1)) begin
            w_tx_nxt   = {1'b0, r_tx[B-1:1]};
            w_mosi_nxt = r_tx[1];
          end
        end
      end
      ST_SHIFT_LO: begin
        if (w_tick) w_state_nxt = (r_bitcnt < CNTW'(B)) ? ST_SHIFT_HI : ST_HOLD;
      end
      ST_HOLD: begin
        if (w_tick) begin
          w_state_nxt   = ST_IDLE;
          w_done_nxt    = 1'b1;
          w_wordout_nxt = r_rx;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_ss_nxt   = !w_busy_nxt;
    w_sclk_nxt = (w_state_nxt == ST_SHIFT_HI) ? !SPI_CPOL : SPI_CPOL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_wordout <= '0;
      r_bitcnt  <= '0;
      r_mosi    <= 1'b0;
      r_ss      <= 1'b1;
      r_sclk    <= SPI_CPOL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_wordout <= w_wordout_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_mosi    <= w_mosi_nxt;
      r_ss      <= w_ss_nxt;
      r_sclk    <= w_sclk_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign wordout = r_wordout;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sclk    = r_sclk;
  assign ss      = r_ss;
  assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus queues expected frames, a monitor
// checks them on each done pulse; a second instance runs DIV=1 back-to-back.
module tb_spi_master;

  localparam int unsigned B     = 8;
  localparam int unsigned DIV   = 2;
  localparam int unsigned FRAME = 2 * DIV * (B + 1);
  localparam int unsigned FRAME1 = 2 * 1 * (B + 1);

  typedef struct {
    logic [B-1:0] tx;
    logic [B-1:0] rx_exp;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [B-1:0] wordin;
  logic [B-1:0] wordout;
  logic         busy, done, sclk, ss, mosi, miso;

  logic         start1;
  logic [B-1:0] wordin1;
  logic [B-1:0] wordout1;
  logic         busy1, done1, sclk1, ss1, mosi1;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  exp_t sb_q[$];

  // Slave-side model state
  bit           loopback = 1'b1;
  logic [B-1:0] slave_word = '0;
  logic         miso_drv = 1'b0;
  logic [B-1:0] mosi_word = '0;
  int           rise_cnt = 0;
  logic         prev_sclk = 1'b0;
  logic         prev_ss = 1'b1;
  bit           sclk_bad = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign miso = loopback ? mosi : miso_drv;

  spi_master #(.B(B), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wordin(wordin),
    .wordout(wordout), .busy(busy), .done(done), .sclk(sclk),
    .ss(ss), .mosi(mosi), .miso(miso)
  );

  spi_master #(.B(B), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .wordin(wordin1),
    .wordout(wordout1), .busy(busy1), .done(done1), .sclk(sclk1),
    .ss(ss1), .mosi(mosi1), .miso(mosi1)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Slave model: records mosi at each rising sclk, updates miso just after it.
  always @(negedge clk) begin
    if (!rst_n) begin
      rise_cnt  = 0;
      mosi_word = '0;
      prev_sclk = 1'b0;
      prev_ss   = 1'b1;
    end else begin
      if (prev_ss && !ss) begin
        rise_cnt  = 0;
        mosi_word = '0;
      end
      if (sclk && !prev_sclk) begin
        if (rise_cnt < B) begin
          mosi_word[rise_cnt] = mosi;
          miso_drv = slave_word[rise_cnt];
        end
        rise_cnt++;
      end
      if (ss && sclk) sclk_bad = 1'b1;
      prev_sclk = sclk;
      prev_ss   = ss;
    end
  end

  // Monitor: every done pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1, expected no pending frame (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wordout", 32'(wordout), 32'(e.rx_exp));
        chk("done_latency", 32'(cyc - e.acc_cyc), 32'(FRAME));
        chk("rising_edges", 32'(rise_cnt), 32'(B));
        chk("mosi_bits", 32'(mosi_word), 32'(e.tx));
        chk("ss_in_done", 32'(ss), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("sclk_with_ss_high", 32'(sclk_bad), 32'd0);
      end
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
      sb_q.delete();
    end
  endtask

  task automatic run_frame(input logic [B-1:0] tx, input logic [B-1:0] sw,
                           input bit lb, input bit poke);
    exp_t e;
    @(negedge clk);
    loopback   = lb;
    slave_word = sw;
    wordin     = tx;
    start      = 1'b1;
    e.tx       = tx;
    e.rx_exp   = lb ? tx : sw;
    e.acc_cyc  = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    wordin = B'($urandom);
    if (poke) begin
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(int'(FRAME) + 10);
  endtask

  initial begin
    int d[2];
    int nd, ss_hi, n, acc1;

    rst_n   = 1'b0;
    start   = 1'b0;
    start1  = 1'b0;
    wordin  = '0;
    wordin1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ss", 32'(ss), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wordout", 32'(wordout), 32'd0);
    rst_n = 1'b1;

    run_frame(8'hA5, 8'h00, 1'b1, 1'b0);
    run_frame(8'h96, 8'h01, 1'b0, 1'b0);
    run_frame(8'h3E, 8'hC3, 1'b0, 1'b0);
    run_frame(8'h5B, 8'h7E, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run_frame(B'($urandom), B'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    run_frame(8'hC3, 8'hC3, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    loopback = 1'b1;
    wordin   = 8'h81;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ss", 32'(ss), 32'd1);
    chk("async_rst_sclk", 32'(sclk), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_wordout", 32'(wordout), 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(8'h6D, 8'hB2, 1'b0, 1'b0);
    run_frame(8'hE7, 8'h00, 1'b1, 1'b0);

    // DIV=1 instance with start held across two frames.
    @(negedge clk);
    wordin1 = 8'h5A;
    start1  = 1'b1;
    acc1    = cyc + 1;
    nd = 0; ss_hi = 0; n = 0;
    while (nd < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (done1) begin
        d[nd] = cyc;
        nd++;
        if (nd == 1) ss_hi = int'(ss1);
        else start1 = 1'b0;
        chk("wordout_div1", 32'(wordout1), 32'h5A);
      end else if (nd == 1) begin
        ss_hi += int'(ss1);
      end
    end
    start1 = 1'b0;
    chk("div1_done_count", 32'(nd), 32'd2);
    if (nd == 2) begin
      chk("div1_first_latency", 32'(d[0] - acc1), 32'(FRAME1));
      chk("div1_done_spacing", 32'(d[1] - d[0]), 32'(FRAME1 + 1));
      chk("div1_ss_high_gap", 32'(ss_hi), 32'd1);
    end

    repeat (5) @(negedge clk);
    chk("pending_frames", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
